// File: rtl/bcd_updown_display.sv
// N-digit BCD up/down counter with programmable decimal wrap limit, tick-enable divider
// and active-low 7-segment decode with optional leading-zero blanking.
module bcd_updown_display #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TICK_HZ    = 1,
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned MAX_VALUE  = 15,
    parameter bit          BLANK_LZ   = 1'b0
) (
    input  logic                      clock50M,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      dir,
    input  logic                      clear,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_bcd,
    output logic [4*NUM_DIGITS-1:0]   bcd,
    output logic [8*NUM_DIGITS-1:0]   seg,
    output logic                      tick,
    output logic                      wrap,
    output logic                      load_err
);

    function automatic logic [4*NUM_DIGITS-1:0] to_bcd(input int unsigned v);
        logic [4*NUM_DIGITS-1:0] r;
        int unsigned             t;
        r = '0;
        t = v;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    localparam int unsigned            DIV_COUNT = CLK_HZ / TICK_HZ - 1;
    localparam int unsigned            DIV_W     = $clog2(DIV_COUNT + 1);
    localparam int unsigned            BW        = 4 * NUM_DIGITS;
    localparam logic [DIV_W-1:0]       DIV_MAX   = DIV_W'(DIV_COUNT);
    localparam logic [BW-1:0]          MAX_BCD   = to_bcd(MAX_VALUE);

    logic [DIV_W-1:0] r_div;
    logic [BW-1:0]    r_value;
    logic             r_wrap;
    logic             r_load_err;

    logic             w_tick;
    logic [BW-1:0]    w_inc;
    logic [BW-1:0]    w_dec;
    logic             w_carry;
    logic             w_borrow;
    logic             w_load_ok;
    logic [BW-1:0]    w_next;
    logic             w_wrap_next;
    logic             w_lerr_next;
    logic             w_lead;

    assign w_tick = (r_div == DIV_MAX);

    // Per-digit BCD increment/decrement; wrap cases are handled separately below.
    always_comb begin
        w_inc     = r_value;
        w_dec     = r_value;
        w_carry   = 1'b1;
        w_borrow  = 1'b1;
        w_load_ok = (load_bcd <= MAX_BCD);
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (w_carry) begin
                if (r_value[4*k +: 4] == 4'd9) begin
                    w_inc[4*k +: 4] = 4'd0;
                end else begin
                    w_inc[4*k +: 4] = r_value[4*k +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_value[4*k +: 4] == 4'd0) begin
                    w_dec[4*k +: 4] = 4'd9;
                end else begin
                    w_dec[4*k +: 4] = r_value[4*k +: 4] - 4'd1;
                    w_borrow        = 1'b0;
                end
            end
            if (load_bcd[4*k +: 4] > 4'd9) begin
                w_load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        w_next      = r_value;
        w_wrap_next = 1'b0;
        w_lerr_next = 1'b0;
        if (clear) begin
            w_next = '0;
        end else if (load) begin
            if (w_load_ok) begin
                w_next = load_bcd;
            end else begin
                w_lerr_next = 1'b1;
            end
        end else if (w_tick && enable) begin
            if (dir) begin
                if (r_value == MAX_BCD) begin
                    w_next      = '0;
                    w_wrap_next = 1'b1;
                end else begin
                    w_next = w_inc;
                end
            end else begin
                if (r_value == '0) begin
                    w_next      = MAX_BCD;
                    w_wrap_next = 1'b1;
                end else begin
                    w_next = w_dec;
                end
            end
        end
    end

    always_ff @(posedge clock50M or negedge reset) begin
        if (!reset) begin
            r_div      <= '0;
            r_value    <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_div      <= w_tick ? '0 : r_div + 1'b1;
            r_value    <= w_next;
            r_wrap     <= w_wrap_next;
            r_load_err <= w_lerr_next;
        end
    end

    // Scan from the top digit so w_lead stays set only while every higher digit is zero.
    always_comb begin
        seg    = '1;
        w_lead = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            w_lead = w_lead && (r_value[4*k +: 4] == 4'd0);
            if (BLANK_LZ && (k != 0) && w_lead) begin
                seg[8*k +: 8] = 8'hFF;
            end else begin
                seg[8*k +: 8] = seg_code(r_value[4*k +: 4]);
            end
        end
    end

    assign bcd      = r_value;
    assign tick     = w_tick;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_updown_display.sv
// Bench for bcd_updown_display: integer reference model, load/clear vector table,
// hand-written corner sequences and randomized stimulus.
module tb_bcd_updown_display;

    localparam int MAXV = 15;
    localparam int DIVC = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        dir = 1'b1;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  load_bcd = 8'h00;
    logic [7:0]  bcd, bcd_b;
    logic [15:0] seg, seg_b;
    logic        tick, wrap, lerr, tick_b, wrap_b, lerr_b;

    bcd_updown_display #(.CLK_HZ(10), .TICK_HZ(1), .NUM_DIGITS(2), .MAX_VALUE(15),
                         .BLANK_LZ(1'b0)) dut (
        .clock50M(clk), .reset(rst_n), .enable(enable), .dir(dir), .clear(clear),
        .load(load), .load_bcd(load_bcd), .bcd(bcd), .seg(seg), .tick(tick),
        .wrap(wrap), .load_err(lerr)
    );

    bcd_updown_display #(.CLK_HZ(10), .TICK_HZ(1), .NUM_DIGITS(2), .MAX_VALUE(15),
                         .BLANK_LZ(1'b1)) dut_b (
        .clock50M(clk), .reset(rst_n), .enable(enable), .dir(dir), .clear(clear),
        .load(load), .load_bcd(load_bcd), .bcd(bcd_b), .seg(seg_b), .tick(tick_b),
        .wrap(wrap_b), .load_err(lerr_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] int_to_bcd(input int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] digit_seg(input int d);
        logic [7:0] tbl [10];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return tbl[d];
    endfunction

    function automatic logic [15:0] exp_seg(input int v, input bit blank);
        logic [7:0] hi;
        hi = (blank && (v / 10) == 0) ? 8'hFF : digit_seg((v / 10) % 10);
        return {hi, digit_seg(v % 10)};
    endfunction

    // Reference model: plain integers for the divider and the decimal value.
    int m_div = 0;
    int m_val = 0;
    bit m_wrap = 1'b0;
    bit m_lerr = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_div  <= 0;
            m_val  <= 0;
            m_wrap <= 1'b0;
            m_lerr <= 1'b0;
        end else begin
            m_div  <= (m_div == DIVC) ? 0 : m_div + 1;
            m_wrap <= 1'b0;
            m_lerr <= 1'b0;
            if (clear) begin
                m_val <= 0;
            end else if (load) begin
                if (load_bcd[3:0] <= 9 && load_bcd[7:4] <= 9
                    && int'(load_bcd[7:4]) * 10 + int'(load_bcd[3:0]) <= MAXV) begin
                    m_val <= int'(load_bcd[7:4]) * 10 + int'(load_bcd[3:0]);
                end else begin
                    m_lerr <= 1'b1;
                end
            end else if (m_div == DIVC && enable) begin
                if (dir) begin
                    m_val  <= (m_val == MAXV) ? 0 : m_val + 1;
                    m_wrap <= (m_val == MAXV);
                end else begin
                    m_val  <= (m_val == 0) ? MAXV : m_val - 1;
                    m_wrap <= (m_val == 0);
                end
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_bcd", bcd, int_to_bcd(m_val));
            check("model_seg", seg, exp_seg(m_val, 1'b0));
            check("model_seg_blank", seg_b, exp_seg(m_val, 1'b1));
            check("model_tick", tick, m_div == DIVC);
            check("model_wrap", wrap, m_wrap);
            check("model_load_err", lerr, m_lerr);
        end
    end

    task automatic wait_tick(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 25 && !seen; i++) begin
            @(negedge clk);
            seen = tick;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no tick, required one within 25 cycles", name);
        end
    endtask

    typedef struct {
        logic       clr;
        logic       ld;
        logic [7:0] lb;
        logic [7:0] exp_bcd;
        logic       exp_err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int cnt;
        int lat;

        vecs[0] = '{1'b0, 1'b1, 8'h12, 8'h12, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'h1A, 8'h12, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 8'h16, 8'h12, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 8'h15, 8'h15, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h9A, 8'h15, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 8'h09, 8'h09, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 8'h1A, 8'h00, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 8'hA0, 8'h00, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 8'h10, 8'h10, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bcd", bcd, 8'h00);
        check("rst_seg", seg, 16'hC0C0);
        check("rst_seg_blank", seg_b, 16'hFFC0);
        check("rst_tick", tick, 1'b0);
        check("rst_wrap", wrap, 1'b0);
        check("rst_load_err", lerr, 1'b0);
        chk_en = 1'b1;

        // Count up through the carry to the wrap limit
        enable = 1'b1;
        dir    = 1'b1;
        #2 rst_n = 1'b1;
        for (int v = 1; v <= MAXV; v++) begin
            wait_tick("up_tick");
            @(negedge clk);
            check("up_bcd", bcd, int_to_bcd(v));
            if (v == 10) check("carry_seg", seg, 16'hF9C0);
        end
        wait_tick("wrap_tick");
        @(negedge clk);
        check("up_wrap_bcd", bcd, 8'h00);
        check("up_wrap_pulse", wrap, 1'b1);
        @(negedge clk);
        check("up_wrap_gone", wrap, 1'b0);

        // Count down from zero
        dir = 1'b0;
        wait_tick("down_tick");
        @(negedge clk);
        check("down_wrap_bcd", bcd, 8'h15);
        check("down_wrap_pulse", wrap, 1'b1);
        wait_tick("down_tick2");
        @(negedge clk);
        check("down_bcd", bcd, 8'h14);
        check("down_no_wrap", wrap, 1'b0);

        // Load/clear vector table, counting disabled
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clear    = vecs[i].clr;
            load     = vecs[i].ld;
            load_bcd = vecs[i].lb;
            @(negedge clk);
            check("vec_bcd", bcd, vecs[i].exp_bcd);
            check("vec_load_err", lerr, vecs[i].exp_err);
            clear = 1'b0;
            load  = 1'b0;
        end

        // Clear and load on a tick cycle: step lost
        load     = 1'b1;
        load_bcd = 8'h07;
        @(negedge clk);
        load = 1'b0;
        check("pre_tick_bcd", bcd, 8'h07);
        wait_tick("clr_tick");
        clear    = 1'b1;
        load     = 1'b1;
        load_bcd = 8'h03;
        enable   = 1'b1;
        dir      = 1'b1;
        @(negedge clk);
        check("clr_tick_bcd", bcd, 8'h00);
        check("clr_tick_wrap", wrap, 1'b0);
        check("clr_tick_err", lerr, 1'b0);
        clear = 1'b0;
        load  = 1'b0;
        wait_tick("after_clr_tick");
        @(negedge clk);
        check("after_clr_bcd", bcd, 8'h01);

        // Hold with enable low: ticks keep running
        enable = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tick) cnt++;
        end
        check("hold_tick_count", cnt, 3);
        check("hold_bcd", bcd, 8'h01);
        load     = 1'b1;
        load_bcd = 8'h05;
        @(negedge clk);
        load = 1'b0;
        check("blank_seg", seg_b, 16'hFF92);
        check("noblank_seg", seg, 16'hC092);

        // Mid-count reset and restart latency
        load     = 1'b1;
        load_bcd = 8'h10;
        @(negedge clk);
        load   = 1'b0;
        enable = 1'b1;
        wait_tick("pre_rst_tick");
        @(negedge clk);
        check("pre_rst_bcd", bcd, 8'h11);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_bcd", bcd, 8'h00);
        check("async_rst_seg", seg, 16'hC0C0);
        check("async_rst_tick", tick, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (lat == 0 && bcd != 8'h00) lat = i;
        end
        check("restart_latency", lat, 10);

        // Randomized stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            clear  = ($urandom % 20) == 0;
            load   = ($urandom % 10) == 0;
            enable = ($urandom % 4) != 0;
            dir    = ($urandom % 3) != 0;
            if ($urandom % 2) load_bcd = int_to_bcd(int'($urandom % 16));
            else load_bcd = 8'($urandom);
            if ($urandom % 400 == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
